mem_copy_engine: RTL and testbench
==================================

// Module: mem_copy_engine
//
// PURPOSE
//   Initiator for one single-port synchronous memory (cs/wen/addr/din/dout, 1-cycle
//   registered read, read-before-write port). Copies a block of LEN words from SRC to
//   DST inside that memory, one word every 2 cycles, with start/busy/done handshake.
//   Sits beside the CPU as a block-move helper; the memory is not shared while busy.
//
// PARAMETERS
//   WIDTH      8    memory cell width in bits
//   ADDR_SIZE  10   memory address width; memory depth = 1<<ADDR_SIZE
//
// PORTS
//   clk        in   1            clock, all state on posedge
//   reset      in   1            asynchronous, active-high; clears all state
//   start      in   1            start request, sampled only in IDLE
//   src        in   ADDR_SIZE    source base address, latched on accepted start
//   dst        in   ADDR_SIZE    destination base address, latched on accepted start
//   len        in   ADDR_SIZE+1  word count, 0..(1<<ADDR_SIZE), latched on accepted start
//   busy       out  1            high while a copy is in progress
//   done       out  1            one-cycle pulse when a copy (incl. len=0) completes
//   count      out  ADDR_SIZE+1  words written so far in current/last copy
//   mem_cs     out  1            memory chip select
//   mem_wen    out  1            memory write enable (valid only with mem_cs)
//   mem_addr   out  ADDR_SIZE    memory address
//   mem_din    out  WIDTH        write data to memory
//   mem_dout   in   WIDTH        registered read data from memory
//
// BEHAVIOUR
//   - Reset: state=IDLE; busy=0, done=0, count=0, mem_cs=0, mem_wen=0, mem_addr=0,
//     mem_din=0; latched src/dst/len cleared. Reset mid-copy aborts immediately; words
//     already written stay written, no done pulse.
//   - FSM states: IDLE, RD, WR.
//     IDLE: start=1 & len!=0 -> latch src,dst,len; count<=0; -> RD.
//           start=1 & len==0 -> stay IDLE, done=1 next cycle, count<=0, no memory access.
//     RD:   mem_cs=1, mem_wen=0, mem_addr=src_l+count. -> WR.
//     WR:   mem_cs=1, mem_wen=1, mem_addr=dst_l+count, mem_din=mem_dout (word read in
//           previous RD cycle, passed straight through). count<=count+1.
//           if count+1==len_l -> IDLE with done=1 next cycle; else -> RD.
//   - busy = (state!=IDLE). done is registered; high exactly one cycle, in the cycle
//     after the last WR (or after accepted len=0 start). Copy of N words: busy for 2N
//     cycles, done at cycle 2N+1 after the start edge.
//   - Outside RD/WR: mem_cs=0, mem_wen=0; mem_addr/mem_din hold don't-care (drive 0).
//   - Address arithmetic is modulo 1<<ADDR_SIZE: src/dst+count wrap past top to 0.
//   - Ascending order only; overlapping ranges with dst>src propagate the source
//     pattern forward (defined, not protected). src==dst rewrites data unchanged.
//   - start while busy is ignored (not queued). len > (1<<ADDR_SIZE) impossible by width.
//   - count holds final value in IDLE until the next accepted start.
//
// CONFIGURATION
//   MEM_COPY_FILL_EN defined: extra inputs fill (1) and fill_data (WIDTH), latched on
//     accepted start. fill=1 -> no RD state; WR every cycle, mem_din=fill_data_l,
//     mem_addr=dst_l+count; N words take N cycles, done at cycle N+1. fill=0 -> copy.
//   MEM_COPY_FILL_EN undefined: ports fill/fill_data absent; copy mode only.
//
// TESTING
//   1. Reset asserted mid-sim -> all outputs 0 same cycle (async), state IDLE.
//   2. mem[0x10..0x13]=A1,B2,C3,D4; start src=0x10 dst=0x80 len=4 -> 8 busy cycles,
//      alternating cs/wen=0/1, done once at cycle 9, mem[0x80..0x83]=A1,B2,C3,D4, count=4.
//   3. src=0x3FE dst=0x001 len=3 (ADDR_SIZE=10) -> reads 0x3FE,0x3FF,0x000; writes
//      0x001..0x003 with original values of those cells (incl. 0x000 before overwrite).
//   4. start with len=0 -> busy stays 0, mem_cs never 1, done pulses next cycle, count=0.
//   5. start pulsed again during busy copy of len=2 -> ignored; exactly one done, 4 busy cycles.
//   6. (MEM_COPY_FILL_EN) fill=1 fill_data=5A dst=0x20 len=5 -> 5 consecutive write
//      cycles, mem[0x20..0x24]=5A, done at cycle 6; reset at cycle 3 -> only 0x20..0x21
//      written, no done.

Source files
------------

// File: rtl/mem_copy_engine_if.sv
// Control and memory-port bundle for mem_copy_engine; fill/fill_data exist only
// when MEM_COPY_FILL_EN is defined.
interface mem_copy_engine_if #(
  parameter int WIDTH     = 8,
  parameter int ADDR_SIZE = 10
);
  logic                 start;
  logic [ADDR_SIZE-1:0] src;
  logic [ADDR_SIZE-1:0] dst;
  logic [ADDR_SIZE:0]   len;
  logic                 busy;
  logic                 done;
  logic [ADDR_SIZE:0]   count;
  logic                 mem_cs;
  logic                 mem_wen;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WIDTH-1:0]     mem_din;
  logic [WIDTH-1:0]     mem_dout;
`ifdef MEM_COPY_FILL_EN
  logic                 fill;
  logic [WIDTH-1:0]     fill_data;
`endif

  modport master (
`ifdef MEM_COPY_FILL_EN
    input  fill, fill_data,
`endif
    input  start, src, dst, len, mem_dout,
    output busy, done, count, mem_cs, mem_wen, mem_addr, mem_din
  );

  modport slave (
`ifdef MEM_COPY_FILL_EN
    output fill, fill_data,
`endif
    output start, src, dst, len, mem_dout,
    input  busy, done, count, mem_cs, mem_wen, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy inside one single-port memory: read/write alternate, one word per 2 cycles;
// done pulses the cycle after the last write. MEM_COPY_FILL_EN adds a 1-word/cycle fill mode.
module mem_copy_engine #(
  parameter int WIDTH     = 8,
  parameter int ADDR_SIZE = 10
) (
  input  logic              clk,
  input  logic              reset,
  mem_copy_engine_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

  state_t               state, state_nxt;
  logic [ADDR_SIZE-1:0] src_l, dst_l;
  logic [ADDR_SIZE:0]   len_l, count, count_nxt, count_inc;
  logic                 done, done_nxt, load;
  logic                 fill_l, fill_in;
  logic [WIDTH-1:0]     fill_data_l, fill_data_in;
  logic                 cs, wen;
  logic [ADDR_SIZE-1:0] addr;
  logic [WIDTH-1:0]     din;

`ifdef MEM_COPY_FILL_EN
  assign fill_in      = bus.fill;
  assign fill_data_in = bus.fill_data;
`else
  assign fill_in      = 1'b0;
  assign fill_data_in = '0;
`endif

  assign count_inc = count + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      done        <= 1'b0;
      count       <= '0;
      src_l       <= '0;
      dst_l       <= '0;
      len_l       <= '0;
      fill_l      <= 1'b0;
      fill_data_l <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      count <= count_nxt;
      if (load) begin
        src_l       <= bus.src;
        dst_l       <= bus.dst;
        len_l       <= bus.len;
        fill_l      <= fill_in;
        fill_data_l <= fill_data_in;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    count_nxt = count;
    load      = 1'b0;
    cs        = 1'b0;
    wen       = 1'b0;
    addr      = '0;
    din       = '0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          count_nxt = '0;
          if (bus.len != '0) begin
            load      = 1'b1;
            state_nxt = fill_in ? WR : RD;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      RD: begin
        cs        = 1'b1;
        addr      = src_l + count[ADDR_SIZE-1:0];
        state_nxt = WR;
      end
      WR: begin
        // Copy data comes straight from the registered read launched in the prior RD cycle.
        cs        = 1'b1;
        wen       = 1'b1;
        addr      = dst_l + count[ADDR_SIZE-1:0];
        din       = fill_l ? fill_data_l : bus.mem_dout;
        count_nxt = count_inc;
        if (count_inc == len_l) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = fill_l ? WR : RD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done;
  assign bus.count    = count;
  assign bus.mem_cs   = cs;
  assign bus.mem_wen  = wen;
  assign bus.mem_addr = addr;
  assign bus.mem_din  = din;
endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: behavioural memory, access scoreboard and reference memory image.
module tb_mem_copy_engine;
  localparam int W  = 8;
  localparam int AS = 10;
  localparam int DEPTH = 1 << AS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic init_mem = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_copy_engine_if #(.WIDTH(W), .ADDR_SIZE(AS)) bus ();

  mem_copy_engine #(.WIDTH(W), .ADDR_SIZE(AS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  function automatic logic [W-1:0] init_val(int i);
    case (i)
      16:      return 8'hA1;
      17:      return 8'hB2;
      18:      return 8'hC3;
      19:      return 8'hD4;
      default: return 8'((i * 29) ^ (i >> 2) ^ 8'h5C);
    endcase
  endfunction

  // Read-before-write memory with 1-cycle registered read.
  logic [W-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
    end else if (bus.mem_cs) begin
      if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_din;
      bus.mem_dout <= mem[bus.mem_addr];
    end
  end

  logic [W-1:0] ref_mem [0:DEPTH-1];

  typedef struct {
    logic          wen;
    logic [AS-1:0] addr;
    logic [W-1:0]  data;
  } acc_t;
  acc_t exp_q[$];

  typedef struct {
    logic [AS-1:0] src;
    logic [AS-1:0] dst;
    logic [AS:0]   len;
    logic          extra_start;
    int            exp_busy;
    int            exp_done;
  } vec_t;
  vec_t vecs[8];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_mem(string name);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(name, bad, 0);
  endtask

  task automatic check_idle_outputs(string name);
    check({name, "_busy"}, bus.busy, 0);
    check({name, "_done"}, bus.done, 0);
    check({name, "_count"}, bus.count, 0);
    check({name, "_cs"}, bus.mem_cs, 0);
    check({name, "_wen"}, bus.mem_wen, 0);
    check({name, "_addr"}, bus.mem_addr, 0);
    check({name, "_din"}, bus.mem_din, 0);
  endtask

  // Drives one copy, pushing every expected memory access, then checks the handshake.
  task automatic run_vec(vec_t v);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int budget = 2 * int'(v.len) + 4;
    acc_t a;
    @(negedge clk);
    bus.start = 1'b1;
    bus.src   = v.src;
    bus.dst   = v.dst;
    bus.len   = v.len;
    for (int i = 0; i < int'(v.len); i++) begin
      logic [AS-1:0] ra, wa;
      ra = v.src + AS'(i);
      wa = v.dst + AS'(i);
      exp_q.push_back('{wen: 1'b0, addr: ra, data: '0});
      exp_q.push_back('{wen: 1'b1, addr: wa, data: ref_mem[ra]});
      ref_mem[wa] = ref_mem[ra];
    end
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (bus.mem_cs) begin
        if (exp_q.size() == 0) begin
          check("unexpected_access", 1, 0);
        end else begin
          a = exp_q.pop_front();
          check("acc_wen", bus.mem_wen, a.wen);
          check("acc_addr", bus.mem_addr, a.addr);
          if (a.wen) check("acc_data", bus.mem_din, a.data);
        end
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (v.extra_start && cyc == 2) begin
        bus.start = 1'b1;
        bus.src   = 10'h000;
        bus.dst   = 10'h3F0;
        bus.len   = 11'd7;
      end
      if (cyc == 3) bus.start = 1'b0;
      @(negedge clk);
    end
    check("busy_cycles", busy_cnt, v.exp_busy);
    check("done_pulses", done_cnt, 1);
    check("done_cycle", done_cyc, v.exp_done);
    check("final_count", bus.count, 32'(v.len));
    check("missing_accesses", exp_q.size(), 0);
    exp_q.delete();
    check_mem("mem_contents");
  endtask

  initial begin
    bus.start = 1'b0;
    bus.src   = '0;
    bus.dst   = '0;
    bus.len   = '0;
`ifdef MEM_COPY_FILL_EN
    bus.fill      = 1'b0;
    bus.fill_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);

    vecs[0] = '{10'h010, 10'h080, 11'd4,    1'b0, 8,    9};
    vecs[1] = '{10'h3FE, 10'h001, 11'd3,    1'b0, 6,    7};
    vecs[2] = '{10'h005, 10'h006, 11'd0,    1'b0, 0,    1};
    vecs[3] = '{10'h040, 10'h050, 11'd2,    1'b1, 4,    5};
    vecs[4] = '{10'h100, 10'h101, 11'd5,    1'b0, 10,   11};
    vecs[5] = '{10'h200, 10'h200, 11'd3,    1'b0, 6,    7};
    vecs[6] = '{10'h2FF, 10'h000, 11'd1,    1'b0, 2,    3};
    vecs[7] = '{10'h000, 10'h200, 11'd1024, 1'b0, 2048, 2049};

    #1;
    check_idle_outputs("reset");
    init_mem = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init_mem = 1'b0;
    reset = 1'b0;
    check_mem("mem_init");

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Reset mid-copy: writes at cycles 2 and 4 survive, the read in cycle 5 is cut off.
    @(negedge clk);
    bus.start = 1'b1;
    bus.src   = 10'h300;
    bus.dst   = 10'h310;
    bus.len   = 11'd6;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", bus.busy, 1);
    check("abort_cs_before", bus.mem_cs, 1);
    #1 reset = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    ref_mem[10'h310] = ref_mem[10'h300];
    ref_mem[10'h311] = ref_mem[10'h301];
    repeat (2) @(negedge clk);
    reset = 1'b0;
    begin
      int done_seen = 0;
      repeat (4) begin
        @(negedge clk);
        if (bus.done || bus.busy || bus.mem_cs) done_seen++;
      end
      check("abort_quiet", done_seen, 0);
    end
    check_mem("abort_mem");

    run_vec('{10'h010, 10'h0C0, 11'd2, 1'b0, 4, 5});

`ifdef MEM_COPY_FILL_EN
    begin
      int wr_cnt = 0;
      int done_cyc = -1;
      for (int pass = 0; pass < 2; pass++) begin
        @(negedge clk);
        bus.start = 1'b1;
        bus.fill = 1'b1;
        bus.fill_data = 8'h5A;
        bus.dst = (pass == 0) ? 10'h020 : 10'h030;
        bus.len = 11'd5;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.fill = 1'b0;
        wr_cnt = 0;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
          if (pass == 1 && cyc == 3) begin
            #1 reset = 1'b1;
            #1;
          end
          if (bus.mem_cs) begin
            check("fill_wen", bus.mem_wen, 1);
            check("fill_addr", bus.mem_addr, 32'(bus.dst) + 32'(wr_cnt));
            check("fill_data", bus.mem_din, 8'h5A);
            wr_cnt++;
          end
          if (bus.done) done_cyc = cyc;
          @(negedge clk);
        end
        reset = 1'b0;
        check("fill_writes", wr_cnt, (pass == 0) ? 5 : 2);
        check("fill_done_cycle", done_cyc, (pass == 0) ? 6 : -1);
        for (int i = 0; i < ((pass == 0) ? 5 : 2); i++)
          ref_mem[((pass == 0) ? 10'h020 : 10'h030) + AS'(i)] = 8'h5A;
        check_mem("fill_mem");
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
